// File: rtl/window_scheduler.sv
// Window sequencer: walks a 4x4 window over a 4-bank row-interleaved feature map and drives sliding_window.
// Optional statistics counters are compiled in with `define WINDOW_SCHED_STATS_EN.
module window_scheduler #(
    parameter int ADDR_W   = 16,
    parameter int DIM_W    = 8,
    parameter int RD_LAT   = 2,
    parameter int V_STRIDE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [DIM_W-1:0]  cfg_img_h,
    input  logic [DIM_W-1:0]  cfg_img_w_words,
    input  logic              ds_ready,
    input  logic              sw_valid_a3,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] rd_addr3,
    output logic              sw_start,
    output logic [DIM_W-1:0]  win_row,
    output logic [DIM_W-1:0]  win_col,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
`ifdef WINDOW_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_windows,
    output logic [31:0]       stat_stall
`endif
);

    localparam int LAT_W  = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam int PROD_W = 2 * DIM_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_WAIT_RD, ST_LAUNCH, ST_WAIT_SW, ST_DRAIN, ST_ADVANCE, ST_FIN
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   base_r;
    logic [DIM_W-1:0]    img_h_r;
    logic [DIM_W-1:0]    img_w_r;
    logic [DIM_W-1:0]    win_row_r;
    logic [DIM_W-1:0]    win_col_r;
    logic [LAT_W-1:0]    lat_cnt_r;
    logic                abort_pend_r;
    logic                rd_en_r;
    logic                sw_start_r;
    logic                busy_r;
    logic                done_r;
    logic                cfg_err_r;
    logic [ADDR_W-1:0]   rd_addr_r [4];

    logic                cfg_bad_s;
    logic [DIM_W:0]      col_next_s;
    logic [DIM_W:0]      row_next_s;
    logic [DIM_W+1:0]    row_end_s;
    logic                col_wrap_s;
    logic                last_win_s;
    logic [DIM_W:0]      row_k_s  [4];
    logic [PROD_W-1:0]   prod_k_s [4];
    logic [ADDR_W-1:0]   addr_s   [4];

`ifdef WINDOW_SCHED_STATS_EN
    logic [31:0]         stat_windows_r;
    logic [31:0]         stat_stall_r;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction
`endif

    // Config check, raster-advance decision and per-bank address arithmetic
    always_comb begin
        cfg_bad_s  = (cfg_img_h < DIM_W'(4)) || (cfg_img_w_words == {DIM_W{1'b0}});
        col_next_s = {1'b0, win_col_r} + (DIM_W+1)'(1);
        col_wrap_s = (col_next_s >= {1'b0, img_w_r});
        row_next_s = {1'b0, win_row_r} + (DIM_W+1)'(V_STRIDE);
        row_end_s  = {1'b0, row_next_s} + (DIM_W+2)'(4);
        last_win_s = col_wrap_s && (row_end_s > {2'b00, img_h_r});
        for (int k = 0; k < 4; k++) begin
            row_k_s[k]  = {1'b0, win_row_r} + (DIM_W+1)'(k);
            prod_k_s[k] = PROD_W'(row_k_s[k]) * PROD_W'(img_w_r);
            addr_s[k]   = base_r + ADDR_W'(prod_k_s[k]) + ADDR_W'(win_col_r);
        end
    end

    // Main sequencer with registered strobes, counters and addresses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            base_r       <= {ADDR_W{1'b0}};
            img_h_r      <= {DIM_W{1'b0}};
            img_w_r      <= {DIM_W{1'b0}};
            win_row_r    <= {DIM_W{1'b0}};
            win_col_r    <= {DIM_W{1'b0}};
            lat_cnt_r    <= {LAT_W{1'b0}};
            abort_pend_r <= 1'b0;
            rd_en_r      <= 1'b0;
            sw_start_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cfg_err_r    <= 1'b0;
            for (int k = 0; k < 4; k++) rd_addr_r[k] <= {ADDR_W{1'b0}};
`ifdef WINDOW_SCHED_STATS_EN
            stat_windows_r <= 32'd0;
            stat_stall_r   <= 32'd0;
`endif
        end else begin
            rd_en_r    <= 1'b0;
            sw_start_r <= 1'b0;
            done_r     <= 1'b0;
            for (int k = 0; k < 4; k++) rd_addr_r[k] <= addr_s[k];
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cfg_err_r    <= cfg_bad_s;
                        abort_pend_r <= 1'b0;
                        if (cfg_bad_s) begin
                            state_r <= ST_FIN;
                            done_r  <= 1'b1;
                        end else begin
                            base_r    <= cfg_base_addr;
                            img_h_r   <= cfg_img_h;
                            img_w_r   <= cfg_img_w_words;
                            win_row_r <= {DIM_W{1'b0}};
                            win_col_r <= {DIM_W{1'b0}};
                            busy_r    <= 1'b1;
                            state_r   <= ST_READ;
`ifdef WINDOW_SCHED_STATS_EN
                            stat_windows_r <= 32'd0;
                            stat_stall_r   <= 32'd0;
`endif
                        end
                    end
                end
                ST_READ: begin
`ifdef WINDOW_SCHED_STATS_EN
                    if (!ds_ready) stat_stall_r <= sat_inc32(stat_stall_r);
`endif
                    if (abort) begin
                        state_r <= ST_FIN;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (ds_ready) begin
                        rd_en_r   <= 1'b1;
                        lat_cnt_r <= {LAT_W{1'b0}};
                        state_r   <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (abort) begin
                        state_r <= ST_FIN;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (lat_cnt_r == LAT_W'(RD_LAT - 1)) begin
                        sw_start_r <= 1'b1;
                        state_r    <= ST_LAUNCH;
`ifdef WINDOW_SCHED_STATS_EN
                        stat_windows_r <= sat_inc32(stat_windows_r);
`endif
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    if (abort) abort_pend_r <= 1'b1;
                    state_r <= ST_WAIT_SW;
                end
                ST_WAIT_SW: begin
                    if (abort) abort_pend_r <= 1'b1;
                    if (sw_valid_a3) state_r <= ST_DRAIN;
                end
                // sliding_window clears its last row this cycle, so no new start may go out yet
                ST_DRAIN: begin
                    if (abort || abort_pend_r) begin
                        state_r <= ST_FIN;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    if (abort || last_win_s) begin
                        state_r <= ST_FIN;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_READ;
                    end
                    if (!abort) begin
                        if (col_wrap_s) begin
                            win_col_r <= {DIM_W{1'b0}};
                            win_row_r <= row_next_s[DIM_W-1:0];
                        end else begin
                            win_col_r <= col_next_s[DIM_W-1:0];
                        end
                    end
                end
                ST_FIN: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en    = rd_en_r;
    assign rd_addr0 = rd_addr_r[0];
    assign rd_addr1 = rd_addr_r[1];
    assign rd_addr2 = rd_addr_r[2];
    assign rd_addr3 = rd_addr_r[3];
    assign sw_start = sw_start_r;
    assign win_row  = win_row_r;
    assign win_col  = win_col_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign cfg_err  = cfg_err_r;
`ifdef WINDOW_SCHED_STATS_EN
    assign stat_windows = stat_windows_r;
    assign stat_stall   = stat_stall_r;
`endif

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler: two instances (V_STRIDE 1 and 2) fed by a sliding_window model
// that raises valid_A3 five cycles after each sw_start.
module tb_window_scheduler;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n, start, abort, ds_ready;
    logic [AW-1:0] cfg_base_addr;
    logic [DW-1:0] cfg_img_h, cfg_img_w_words;

    logic          rd_en, sw_start, busy, done, cfg_err, sw_valid;
    logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [DW-1:0] win_row, win_col;
    logic          rd_en_b, sw_start_b, busy_b, done_b, cfg_err_b, sw_valid_b;
    logic [AW-1:0] rd_addr0_b, rd_addr1_b, rd_addr2_b, rd_addr3_b;
    logic [DW-1:0] win_row_b, win_col_b;
    logic [2:0]    swc, swc_b;
`ifdef WINDOW_SCHED_STATS_EN
    logic [31:0]   stat_windows, stat_stall, stat_windows_b, stat_stall_b;
`endif

    int vectors = 0;
    int miscompares = 0;
    int n_rd[2]   = '{0, 0};
    int n_sw[2]   = '{0, 0};
    int n_done[2] = '{0, 0};
    logic [AW-1:0] a_log [64][4];
    logic [DW-1:0] row_log [2][64];
    logic [DW-1:0] col_log [64];

    always #5 clk = ~clk;

    window_scheduler #(.ADDR_W(AW), .DIM_W(DW), .RD_LAT(2), .V_STRIDE(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_base_addr(cfg_base_addr), .cfg_img_h(cfg_img_h), .cfg_img_w_words(cfg_img_w_words),
        .ds_ready(ds_ready), .sw_valid_a3(sw_valid), .rd_en(rd_en),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
        .sw_start(sw_start), .win_row(win_row), .win_col(win_col),
        .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef WINDOW_SCHED_STATS_EN
        , .stat_windows(stat_windows), .stat_stall(stat_stall)
`endif
    );

    window_scheduler #(.ADDR_W(AW), .DIM_W(DW), .RD_LAT(2), .V_STRIDE(2)) u_dut_s2 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_base_addr(cfg_base_addr), .cfg_img_h(cfg_img_h), .cfg_img_w_words(cfg_img_w_words),
        .ds_ready(ds_ready), .sw_valid_a3(sw_valid_b), .rd_en(rd_en_b),
        .rd_addr0(rd_addr0_b), .rd_addr1(rd_addr1_b), .rd_addr2(rd_addr2_b), .rd_addr3(rd_addr3_b),
        .sw_start(sw_start_b), .win_row(win_row_b), .win_col(win_col_b),
        .busy(busy_b), .done(done_b), .cfg_err(cfg_err_b)
`ifdef WINDOW_SCHED_STATS_EN
        , .stat_windows(stat_windows_b), .stat_stall(stat_stall_b)
`endif
    );

    // sliding_window model: valid_A3 is high in the fifth cycle after the sw_start cycle
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swc   <= 3'd0;
            swc_b <= 3'd0;
        end else begin
            if (sw_start) swc <= 3'd5; else if (swc != 3'd0) swc <= swc - 3'd1;
            if (sw_start_b) swc_b <= 3'd5; else if (swc_b != 3'd0) swc_b <= swc_b - 3'd1;
        end
    end
    assign sw_valid   = (swc == 3'd1);
    assign sw_valid_b = (swc_b == 3'd1);

    // Event log: bank reads, launched windows and done pulses of both instances
    always @(posedge clk) begin
        if (rd_en) begin
            a_log[n_rd[0] % 64][0] <= rd_addr0;
            a_log[n_rd[0] % 64][1] <= rd_addr1;
            a_log[n_rd[0] % 64][2] <= rd_addr2;
            a_log[n_rd[0] % 64][3] <= rd_addr3;
            n_rd[0] <= n_rd[0] + 1;
        end
        if (sw_start) begin
            row_log[0][n_sw[0] % 64] <= win_row;
            col_log[n_sw[0] % 64]    <= win_col;
            n_sw[0] <= n_sw[0] + 1;
        end
        if (done) n_done[0] <= n_done[0] + 1;
        if (rd_en_b) n_rd[1] <= n_rd[1] + 1;
        if (sw_start_b) begin
            row_log[1][n_sw[1] % 64] <= win_row_b;
            n_sw[1] <= n_sw[1] + 1;
        end
        if (done_b) n_done[1] <= n_done[1] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_layer(input logic [DW-1:0] h, input logic [DW-1:0] w, input logic [AW-1:0] base);
        @(negedge clk);
        cfg_img_h = h; cfg_img_w_words = w; cfg_base_addr = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int s0, input int s1, input string tag);
        int k = 0;
        while ((n_done[0] == s0 || n_done[1] == s1) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, 32'(k < 1000), 32'd1);
        repeat (4) @(negedge clk);
        check({tag, "_done_once"}, 32'(n_done[0] - s0), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    logic [AW-1:0] exp_t1 [8] = '{16'h0100, 16'h0102, 16'h0104, 16'h0106,
                                 16'h0101, 16'h0103, 16'h0105, 16'h0107};
    int sr, ss, sd, sd1, ss1, k;
    logic saw;

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; ds_ready = 1'b1;
        cfg_base_addr = 16'h0000; cfg_img_h = 8'd0; cfg_img_w_words = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_addr0", 32'(rd_addr0), 32'd0);
        reset_n = 1'b1;

        // 4x2 words at 0x100: two windows in raster order
        sr = n_rd[0]; ss = n_sw[0]; sd = n_done[0]; sd1 = n_done[1];
        start_layer(8'd4, 8'd2, 16'h0100);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(sd, sd1, "t1");
        check("t1_reads", 32'(n_rd[0] - sr), 32'd2);
        check("t1_starts", 32'(n_sw[0] - ss), 32'd2);
        for (int i = 0; i < 8; i++)
            check($sformatf("t1_addr%0d", i), 32'(a_log[(sr + i / 4) % 64][i % 4]), 32'(exp_t1[i]));
        check("t1_col1", 32'(col_log[(ss + 1) % 64]), 32'd1);
`ifdef WINDOW_SCHED_STATS_EN
        check("t1_stat_win", stat_windows, 32'd2);
        check("t1_stat_stall", stat_stall, 32'd0);
`endif

        // 6 rows x 1 word: stride 1 gives rows 0,1,2; stride 2 gives rows 0,2
        ss = n_sw[0]; ss1 = n_sw[1]; sd = n_done[0]; sd1 = n_done[1];
        start_layer(8'd6, 8'd1, 16'h0000);
        wait_done(sd, sd1, "t2");
        check("t2_s1_starts", 32'(n_sw[0] - ss), 32'd3);
        check("t2_s1_row0", 32'(row_log[0][ss % 64]), 32'd0);
        check("t2_s1_row1", 32'(row_log[0][(ss + 1) % 64]), 32'd1);
        check("t2_s1_row2", 32'(row_log[0][(ss + 2) % 64]), 32'd2);
        check("t2_s2_starts", 32'(n_sw[1] - ss1), 32'd2);
        check("t2_s2_row0", 32'(row_log[1][ss1 % 64]), 32'd0);
        check("t2_s2_row1", 32'(row_log[1][(ss1 + 1) % 64]), 32'd2);

        // ds_ready low for ten READ cycles
        ds_ready = 1'b0;
        sd = n_done[0]; sd1 = n_done[1];
        start_layer(8'd4, 8'd1, 16'h0010);
        saw = rd_en;
        repeat (10) begin
            @(negedge clk);
            saw = saw | rd_en;
        end
        check("t3_no_rd_stalled", 32'(saw), 32'd0);
        ds_ready = 1'b1;
        @(negedge clk);
        check("t3_rd_after_ready", 32'(rd_en), 32'd1);
        check("t3_rd_addr1", 32'(rd_addr1), 32'h0011);
        wait_done(sd, sd1, "t3");
`ifdef WINDOW_SCHED_STATS_EN
        check("t3_stat_stall", stat_stall, 32'd10);
        check("t3_stat_win", stat_windows, 32'd1);
`endif

        // Too few rows: error flag, done pulse, no traffic; a good start clears the flag
        sr = n_rd[0]; ss = n_sw[0]; sd = n_done[0];
        start_layer(8'd3, 8'd2, 16'h0000);
        check("t4_cfg_err", 32'(cfg_err), 32'd1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t4_done_pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_reads", 32'(n_rd[0] - sr), 32'd0);
        check("t4_starts", 32'(n_sw[0] - ss), 32'd0);
        check("t4_done_cnt", 32'(n_done[0] - sd), 32'd1);
        sd = n_done[0]; sd1 = n_done[1];
        start_layer(8'd4, 8'd1, 16'h0000);
        check("t4_err_cleared", 32'(cfg_err), 32'd0);
        check("t4_busy_valid", 32'(busy), 32'd1);
        wait_done(sd, sd1, "t4b");
        start_layer(8'd8, 8'd0, 16'h0000);
        check("t4_zero_width", 32'(cfg_err), 32'd1);
        repeat (3) @(negedge clk);

        // Abort in WAIT_SW of the first of four windows
        sr = n_rd[0]; ss = n_sw[0]; sd = n_done[0];
        start_layer(8'd4, 8'd4, 16'h0000);
        k = 0;
        while (!sw_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t5_launch_seen", 32'(sw_start), 32'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        k = 2;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t5_launch_to_done", 32'(k), 32'd7);
        repeat (4) @(negedge clk);
        check("t5_starts", 32'(n_sw[0] - ss), 32'd1);
        check("t5_reads", 32'(n_rd[0] - sr), 32'd1);
        check("t5_done_cnt", 32'(n_done[0] - sd), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);

        // Abort in READ: done next cycle, no read
        ds_ready = 1'b0;
        sr = n_rd[0];
        start_layer(8'd4, 8'd1, 16'h0000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_done", 32'(done), 32'd1);
        ds_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_reads", 32'(n_rd[0] - sr), 32'd0);

        // Asynchronous reset during WAIT_RD, then a clean layer
        start_layer(8'd4, 8'd1, 16'h0200);
        k = 0;
        while (!rd_en && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t7_pre_rd_en", 32'(rd_en), 32'd1);
        check("t7_pre_addr0", 32'(rd_addr0), 32'h0200);
        #1 reset_n = 1'b0;
        #1;
        check("t7_rst_rd_en", 32'(rd_en), 32'd0);
        check("t7_rst_addr0", 32'(rd_addr0), 32'd0);
        check("t7_rst_addr3", 32'(rd_addr3), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sr = n_rd[0]; ss = n_sw[0]; sd = n_done[0]; sd1 = n_done[1];
        start_layer(8'd4, 8'd1, 16'h0040);
        wait_done(sd, sd1, "t7");
        check("t7_reads", 32'(n_rd[0] - sr), 32'd1);
        check("t7_addr0", 32'(a_log[sr % 64][0]), 32'h0040);
        check("t7_addr3", 32'(a_log[sr % 64][3]), 32'h0043);
        check("t7_row", 32'(row_log[0][ss % 64]), 32'd0);
        check("t7_col", 32'(col_log[ss % 64]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
